cnn_layer_sequencer: RTL and testbench
======================================

// Module: cnn_layer_sequencer
// PURPOSE
//  Top-level scheduler for the CNN accelerator: on one axisif_start it runs NUM_LAYERS layer engines
//  (convolution, pooling, dense) strictly in order, one at a time. It drives each engine's start and
//  tracks its done, selects the ping-pong feature-map bank, enforces a per-layer watchdog and counts
//  inference cycles. It does not touch the data path.
// PARAMETERS
//  NUM_LAYERS      4        number of layer engines, sequenced 0..NUM_LAYERS-1 (>=1)
//  IDX_WIDTH       2        width of layer_idx, >= clog2(NUM_LAYERS)
//  TIMEOUT_WIDTH   20       watchdog counter width
//  TIMEOUT_CYCLES  1000000  max cycles per LAUNCH or RUN phase; 0 disables the watchdog
//  CYC_WIDTH       32       width of cycle_count
// PORTS
//  clk            in   1               clock, rising edge
//  rst_n          in   1               reset, synchronous, active-low
//  axisif_start   in   1               start one inference; sampled in IDLE only
//  axisif_err_clr in   1               clears ERROR, returns to IDLE
//  axisif_done    out  1               level, high while IDLE
//  axisif_err     out  1               level, high while ERROR
//  busy           out  1               high in LAUNCH/RUN/NEXT
//  layer_start    out  NUM_LAYERS      one-hot start to engine layer_idx
//  layer_done     in   NUM_LAYERS      per-engine done level (high when engine idle)
//  layer_idx      out  IDX_WIDTH       index of current layer
//  buf_sel        out  1               current layer reads bank buf_sel, writes bank ~buf_sel
//  cycle_count    out  CYC_WIDTH       cycles spent in last/current inference
// BEHAVIOUR
//  Reset: rst_n low at a clk edge -> state IDLE, layer_idx=0, buf_sel=0, watchdog=0, cycle_count=0.
//   Outputs after that edge: done=1, err=0, busy=0, layer_start=0. Applies mid-operation too;
//   there is no partial state. Engines are not reset by this block.
//  Moore outputs, decoded from registered state/idx only. No combinational path from inputs.
//  States:
//   IDLE:   done=1. axisif_start=1 -> LAUNCH; layer_idx<=0, buf_sel<=0, cycle_count<=0, wdog<=0.
//   LAUNCH: layer_start[layer_idx]=1, held. layer_done[layer_idx]=0 -> RUN, wdog<=0.
//           Otherwise stay; wdog increments.
//   RUN:    layer_start=0. layer_done[layer_idx]=1 -> NEXT. Otherwise stay; wdog increments.
//   NEXT:   one cycle. If layer_idx==NUM_LAYERS-1 -> IDLE. Else layer_idx+1, buf_sel toggles,
//           wdog<=0, -> LAUNCH.
//   ERROR:  err=1, done=0, busy=0, layer_start=0. axisif_err_clr=1 -> IDLE.
//  Watchdog: TIMEOUT_CYCLES!=0 and wdog==TIMEOUT_CYCLES-1 in LAUNCH or RUN with the exit condition
//   false -> ERROR. An exit condition true on the same cycle wins. layer_idx/buf_sel freeze in ERROR
//   for debug; they reset on the next accepted start.
//  cycle_count: increments (saturating at all-ones) on every cycle in LAUNCH/RUN/NEXT.
//   Frozen in IDLE and ERROR.
//  Per-layer cost: 2 LAUNCH + B RUN + 1 NEXT cycles, for an engine whose done drops the cycle after
//   start and stays low B cycles.
//  Ignored inputs: axisif_start outside IDLE. axisif_err_clr outside ERROR. layer_done of non-current
//   engines.
//  Simultaneous events: start+err_clr in ERROR -> IDLE only; start is not taken.
//   start held high continuously -> a new inference launches the cycle after returning to IDLE,
//   so done is high for exactly one cycle.
// TESTING
//  1 Reset: rst_n=0 for 2 edges mid-RUN -> done=1, err=0, busy=0, layer_start=0, idx=0,
//    buf_sel=0, cycle_count=0.
//  2 Nominal: NUM_LAYERS=3 with engine models B=10 -> layer_start 001,010,100 in order, buf_sel 0,1,0,
//    done rises once, cycle_count=39.
//  3 Start while busy: pulse axisif_start during layer 1 RUN -> no effect; idx/buf_sel/count as in
//    test 2.
//  4 Timeout: TIMEOUT_CYCLES=16, engine 1 never drops done -> err=1 after 16 LAUNCH cycles,
//    layer_start=0, idx=1; err_clr -> done=1 next cycle.
//  5 Timeout race: engine 2 done rises on the wdog==15 cycle of RUN -> NEXT, no error.
//  6 Clear/start race: err_clr and start together in ERROR -> IDLE, no layer_start;
//    start next cycle -> LAUNCH idx=0.

Source files
------------

// File: rtl/cnn_layer_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_layer_sequencer_if: host control and layer-engine handshake bundle.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cnn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int CYC_WIDTH  = 32
);
  logic                  axisif_start;
  logic                  axisif_err_clr;
  logic                  axisif_done;
  logic                  axisif_err;
  logic                  busy;
  logic [NUM_LAYERS-1:0] layer_start;
  logic [NUM_LAYERS-1:0] layer_done;
  logic [IDX_WIDTH-1:0]  layer_idx;
  logic                  buf_sel;
  logic [CYC_WIDTH-1:0]  cycle_count;

  // Host and layer engines together form the master side.
  modport master (
    output axisif_start, axisif_err_clr, layer_done,
    input  axisif_done, axisif_err, busy, layer_start, layer_idx, buf_sel, cycle_count
  );

  modport slave (
    input  axisif_start, axisif_err_clr, layer_done,
    output axisif_done, axisif_err, busy, layer_start, layer_idx, buf_sel, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_layer_sequencer: runs the layer engines in order with per-phase      |
// | watchdog, ping-pong bank select and inference cycle counter.  Rev 1.0    |
// +--------------------------------------------------------------------------+
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 4,
  parameter int IDX_WIDTH      = 2,
  parameter int TIMEOUT_WIDTH  = 20,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CYC_WIDTH      = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  cnn_layer_sequencer_if.slave  bus
);

  localparam logic [IDX_WIDTH-1:0]     LAST_IDX  = IDX_WIDTH'(NUM_LAYERS - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit                       WDOG_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_NEXT   = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic                    buf_q, buf_d;
  logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
  logic [CYC_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [NUM_LAYERS-1:0]   start_q, start_d;
  logic                    cur_done;
  logic                    wdog_expired;

  function automatic logic [NUM_LAYERS-1:0] sel_of(input logic [IDX_WIDTH-1:0] i);
    return NUM_LAYERS'(1) << i;
  endfunction

  assign cur_done     = |(bus.layer_done & sel_of(idx_q));
  assign wdog_expired = WDOG_EN && (wdog_q == WDOG_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    wdog_d  = wdog_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.axisif_start) begin
          state_d = ST_LAUNCH;
          idx_d   = '0;
          buf_d   = 1'b0;
          cnt_d   = '0;
          wdog_d  = '0;
        end
      end
      ST_LAUNCH: begin
        // A leaving condition on the expiry cycle wins over the timeout.
        if (!cur_done) begin
          state_d = ST_RUN;
          wdog_d  = '0;
        end else if (wdog_expired) begin
          state_d = ST_ERROR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (cur_done) begin
          state_d = ST_NEXT;
        end else if (wdog_expired) begin
          state_d = ST_ERROR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LAUNCH;
          idx_d   = idx_q + 1'b1;
          buf_d   = ~buf_q;
          wdog_d  = '0;
        end
      end
      ST_ERROR: begin
        if (bus.axisif_err_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_LAUNCH || state_q == ST_RUN || state_q == ST_NEXT) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so they appear registered with it.
    done_d  = (state_d == ST_IDLE);
    err_d   = (state_d == ST_ERROR);
    busy_d  = (state_d == ST_LAUNCH) || (state_d == ST_RUN) || (state_d == ST_NEXT);
    start_d = (state_d == ST_LAUNCH) ? sel_of(idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      buf_q   <= 1'b0;
      wdog_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b1;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end

  assign bus.axisif_done = done_q;
  assign bus.axisif_err  = err_q;
  assign bus.busy        = busy_q;
  assign bus.layer_start = start_q;
  assign bus.layer_idx   = idx_q;
  assign bus.buf_sel     = buf_q;
  assign bus.cycle_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cnn_layer_sequencer: directed scoreboard bench, three engine models.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cnn_layer_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnn_layer_sequencer_if #(.NUM_LAYERS(3), .IDX_WIDTH(2), .CYC_WIDTH(32)) bus ();

  cnn_layer_sequencer #(
    .NUM_LAYERS(3), .IDX_WIDTH(2), .TIMEOUT_WIDTH(20), .TIMEOUT_CYCLES(16), .CYC_WIDTH(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Engine model: done drops the cycle after start, stays low eng_b cycles.
  logic [2:0] eng_done = 3'b111;
  int         eng_cnt [3];
  int         eng_b   [3];
  bit [2:0]   eng_stuck;

  assign bus.layer_done = eng_done;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (eng_done[i]) begin
        if (bus.layer_start[i] && !eng_stuck[i]) begin
          eng_done[i] <= 1'b0;
          eng_cnt[i]  <= 1;
        end
      end else if (eng_cnt[i] >= eng_b[i]) begin
        eng_done[i] <= 1'b1;
      end else begin
        eng_cnt[i] <= eng_cnt[i] + 1;
      end
    end
  end

  typedef struct {
    string       name;
    logic [40:0] exp;
  } exp_t;

  exp_t q[$];
  bit   mon_en     = 1'b0;
  bit   probe      = 1'b0;
  bit   finish_req = 1'b0;
  int   n_tests    = 0;
  int   n_fail     = 0;

  function automatic logic [40:0] snap(input logic [2:0] ls, input logic [1:0] idx,
                                       input logic bs, input logic dn, input logic er,
                                       input logic bz, input logic [31:0] cnt);
    return {ls, idx, bs, dn, er, bz, cnt};
  endfunction

  function automatic void push(input string nm, input logic [40:0] e);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    q.push_back(x);
  endfunction

  function automatic void push_launch(input int k, input int cnt);
    push($sformatf("launch%0d", k),
         snap(3'(1 << k), 2'(k), 1'(k % 2), 1'b0, 1'b0, 1'b1, 32'(cnt)));
  endfunction

  // Full inference: 2 LAUNCH + B RUN + 1 NEXT cycles per layer.
  function automatic void push_run(input int b0, input int b1, input int b2);
    push_launch(0, 0);
    push_launch(1, b0 + 3);
    push_launch(2, b0 + b1 + 6);
    push("done", snap(3'b000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'(b0 + b1 + b2 + 9)));
  endfunction

  // Engine 1 stuck: layer 0 completes, layer 1 times out after 16 LAUNCH cycles.
  function automatic void push_timeout();
    push_launch(0, 0);
    push_launch(1, 13);
    push("timeout_err", snap(3'b000, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd29));
  endfunction

  // Monitor: every observable event pops one expectation.
  logic [2:0]  prev_ls;
  logic        prev_done, prev_err;
  logic [40:0] cur;

  always @(negedge clk) begin
    int   nev;
    exp_t e;
    cur = snap(bus.layer_start, bus.layer_idx, bus.buf_sel, bus.axisif_done,
               bus.axisif_err, bus.busy, bus.cycle_count);
    if (mon_en) begin
      nev = 0;
      if (bus.axisif_err && !prev_err) nev++;
      if (bus.axisif_done && !prev_done) nev++;
      if (bus.layer_start != 3'b000 && bus.layer_start != prev_ls) nev++;
      if (probe) nev++;
      for (int k = 0; k < nev; k++) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event actual=%h required=none", cur);
        end else begin
          e = q.pop_front();
          if (cur !== e.exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", e.name, cur, e.exp);
          end
        end
      end
      if (finish_req) begin
        n_tests++;
        if (q.size() != 0) begin
          n_fail++;
          $display("FAIL missing_events actual=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
    prev_ls   = bus.layer_start;
    prev_done = bus.axisif_done;
    prev_err  = bus.axisif_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.axisif_start = 1'b1;
    tick();
    bus.axisif_start = 1'b0;
  endtask

  task automatic do_probe();
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.axisif_done) break;
    end
  endtask

  task automatic wait_err(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.axisif_err) break;
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.axisif_start   = 1'b0;
    bus.axisif_err_clr = 1'b0;
    eng_b              = '{10, 10, 10};
    eng_stuck          = 3'b000;
    repeat (3) tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push("reset_state", snap(3'b000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
    do_probe();

    // Reset asserted for two edges in the middle of layer 0 RUN.
    push_launch(0, 0);
    push("mid_run_reset", snap(3'b000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
    tick();
    pulse_start();
    repeat (5) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();

    // Nominal three-layer inference.
    push_run(10, 10, 10);
    pulse_start();
    wait_done(200);
    tick();

    // Start pulse during layer 1 RUN is ignored.
    push_run(10, 10, 10);
    pulse_start();
    repeat (19) tick();
    pulse_start();
    wait_done(200);
    tick();

    // Timeout in LAUNCH, then error clear returns to IDLE the next cycle.
    eng_stuck[1] = 1'b1;
    push_timeout();
    pulse_start();
    wait_err(100);
    push("clr_done", snap(3'b000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd29));
    push("clr_next_cycle", snap(3'b000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd29));
    bus.axisif_err_clr = 1'b1;
    tick();
    bus.axisif_err_clr = 1'b0;
    do_probe();
    eng_stuck[1] = 1'b0;
    tick();

    // Engine 2 done rises on the last watchdog cycle of RUN: no error.
    eng_b[2] = 16;
    push_run(10, 10, 16);
    pulse_start();
    wait_done(200);
    eng_b[2] = 10;
    tick();

    // err_clr and start together in ERROR: IDLE only, then start launches.
    eng_stuck[1] = 1'b1;
    push_timeout();
    pulse_start();
    wait_err(100);
    eng_stuck[1] = 1'b0;
    push("race_idle", snap(3'b000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd29));
    push_run(10, 10, 10);
    bus.axisif_start   = 1'b1;
    bus.axisif_err_clr = 1'b1;
    tick();
    bus.axisif_err_clr = 1'b0;
    tick();
    bus.axisif_start = 1'b0;
    wait_done(200);
    repeat (3) tick();

    finish_req = 1'b1;
    repeat (10) tick();
    $display("FAIL monitor_did_not_finish actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
